// File: rtl/spike_event_rx_pkg.sv
// Shared definitions for the spike event receiver: spike id width, event word
// field offsets and a saturating increment helper.
package spike_event_rx_pkg;

  localparam int SPKID_W   = 16;
  localparam int SPKID_LSB = 0;
  localparam int TS_LSB    = SPKID_W;

  // Increments value by one when inc is set, but never beyond maxVal.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic        inc,
                                          input logic [31:0] maxVal);
    return (inc && (value < maxVal)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/spike_event_rx_if.sv
// Host-facing bundle of the spike event receiver: spike input, rate window
// control and results, and the event FIFO read port.
interface spike_event_rx_if
  import spike_event_rx_pkg::*;
#(
  parameter int CW  = 16,
  parameter int AW  = 4,
  parameter int TSW = 16
) ();

  logic                   enable;
  logic                   spike_in;
  logic [SPKID_W-1:0]     spkid_in;
  logic [31:0]            window_len;
  logic [CW-1:0]          spike_count;
  logic                   count_valid;
  logic                   rd_en;
  logic [TSW+SPKID_W-1:0] rd_data;
  logic                   rd_valid;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [AW:0]            fifo_level;
  logic [15:0]            drop_cnt;

  modport master (
    output enable, spike_in, spkid_in, window_len, rd_en,
    input  spike_count, count_valid, rd_data, rd_valid,
           fifo_empty, fifo_full, fifo_level, drop_cnt
  );

  modport slave (
    input  enable, spike_in, spkid_in, window_len, rd_en,
    output spike_count, count_valid, rd_data, rd_valid,
           fifo_empty, fifo_full, fifo_level, drop_cnt
  );

endinterface

// File: rtl/spike_event_rx_fifo.sv
// Synchronous event FIFO with registered read data and registered
// empty/full/level flags that already reflect this cycle's push and pop.
module spike_event_fifo #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic          rawclk,
  input  logic          reset_sim,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_rdValid,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_level
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_empty;
  logic          r_full;
  logic          r_rdValid;
  logic [W-1:0]  r_rdata;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_levelNext;

  assign w_push      = i_push & ~r_full;
  assign w_pop       = i_pop & ~r_empty;
  assign w_levelNext = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);

  // Pointers wrap naturally at 2**AW; the level counter disambiguates full/empty.
  always_ff @(posedge rawclk or posedge reset_sim) begin
    if (reset_sim) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_rdValid <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rdata <= r_mem[r_rptr];
        r_rptr  <= r_rptr + AW'(1);
      end
      r_rdValid <= w_pop;
      r_level   <= w_levelNext;
      r_empty   <= (w_levelNext == '0);
      r_full    <= (w_levelNext == (AW+1)'(DEPTH));
    end
  end

  assign o_rdata   = r_rdata;
  assign o_rdValid = r_rdValid;
  assign o_empty   = r_empty;
  assign o_full    = r_full;
  assign o_level   = r_level;

endmodule

// File: rtl/spike_event_rx.sv
// Motoneuron spike receiver: rising-edge detection, per-window firing rate
// counting and timestamped event queueing for host readout.
module spike_event_rx
  import spike_event_rx_pkg::*;
#(
  parameter int CW  = 16,
  parameter int AW  = 4,
  parameter int TSW = 16
) (
  input  logic           rawclk,
  input  logic           reset_sim,
  spike_event_rx_if.slave bus
);

  localparam logic [31:0] CMAX = 32'((64'd1 << CW) - 64'd1);

  logic                   r_spikeD;
  logic [TSW-1:0]         r_ts;
  logic [31:0]            r_winCnt;
  logic [CW-1:0]          r_acc;
  logic [CW-1:0]          r_spikeCount;
  logic                   r_countValid;
  logic [15:0]            r_dropCnt;

  logic                   w_edge;
  logic                   w_terminal;
  logic                   w_full;
  logic                   w_push;
  logic [TSW+SPKID_W-1:0] w_word;

  assign w_edge     = bus.spike_in & ~r_spikeD & bus.enable;
  assign w_terminal = (r_winCnt == bus.window_len - 32'd1);
  assign w_push     = w_edge & ~w_full;
  assign w_word     = {r_ts, bus.spkid_in};

  // A spike level held across reset release counts once, since r_spikeD resets low.
  always_ff @(posedge rawclk or posedge reset_sim) begin
    if (reset_sim) begin
      r_spikeD     <= 1'b0;
      r_ts         <= '0;
      r_winCnt     <= '0;
      r_acc        <= '0;
      r_spikeCount <= '0;
      r_countValid <= 1'b0;
      r_dropCnt    <= '0;
    end else begin
      r_spikeD     <= bus.spike_in;
      r_ts         <= r_ts + TSW'(1);
      r_countValid <= 1'b0;
      if (!bus.enable || (bus.window_len == 32'd0)) begin
        r_winCnt <= '0;
        r_acc    <= '0;
      end else if (w_terminal) begin
        r_spikeCount <= CW'(sat_inc(32'(r_acc), w_edge, CMAX));
        r_countValid <= 1'b1;
        r_acc        <= '0;
        r_winCnt     <= '0;
      end else begin
        r_acc    <= CW'(sat_inc(32'(r_acc), w_edge, CMAX));
        r_winCnt <= r_winCnt + 32'd1;
      end
      if (w_edge && w_full) r_dropCnt <= 16'(sat_inc(32'(r_dropCnt), 1'b1, 32'h0000_FFFF));
    end
  end

  spike_event_fifo #(
    .W  (TSW + SPKID_W),
    .AW (AW)
  ) u_fifo (
    .rawclk    (rawclk),
    .reset_sim (reset_sim),
    .i_push    (w_push),
    .i_wdata   (w_word),
    .i_pop     (bus.rd_en),
    .o_rdata   (bus.rd_data),
    .o_rdValid (bus.rd_valid),
    .o_empty   (bus.fifo_empty),
    .o_full    (w_full),
    .o_level   (bus.fifo_level)
  );

  assign bus.fifo_full   = w_full;
  assign bus.spike_count = r_spikeCount;
  assign bus.count_valid = r_countValid;
  assign bus.drop_cnt    = r_dropCnt;

endmodule
